// File: rtl/seg_scan_capture_pkg.sv
// Shared constants for the seven-segment scan capture block.
// GAME OVER message (digit 0 at index 0), blank pattern, FSM states.
package seg_pkg;

  localparam logic [6:0] BLANK = 7'b1111111;

  // Active-low gfedcba, digit 7 first in the literal.
  localparam logic [7:0][6:0] GAME_OVER_MSG = {
    7'b0000010, 7'b0001000, 7'b1001000, 7'b0000110,
    7'b1000000, 7'b1000001, 7'b0000110, 7'b0001000
  };

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_COLLECT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scanned display bus plus capture-buffer read/status signals.
// master: display side / bench; slave: the capture monitor.
interface seg_scan_capture_if;
  logic       an0, an1, an2, an3;
  logic       an4, an5, an6, an7;
  logic [6:0] seg_in;
  logic [2:0] rd_idx;
  logic [6:0] rd_seg;
  logic       frame_done;
  logic       frame_err;
  logic       match;
  logic       synced;

  modport master (
    output an0, an1, an2, an3,
    output an4, an5, an6, an7,
    output seg_in, rd_idx,
    input  rd_seg, frame_done,
    input  frame_err, match, synced
  );

  modport slave (
    input  an0, an1, an2, an3,
    input  an4, an5, an6, an7,
    input  seg_in, rd_idx,
    output rd_seg, frame_done,
    output frame_err, match, synced
  );
endinterface

// File: rtl/seg_scan_capture_stable_detect.sv
// Anode decode and dwell-stability tracker for the scan monitor.
// Ports: i_an/i_seg sample in; o_commit/o_idx/o_pattern/o_illegal out.
module seg_stable_detect #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_an,
  input  logic [6:0] i_seg,
  output logic       o_commit,
  output logic [2:0] o_idx,
  output logic [6:0] o_pattern,
  output logic       o_illegal
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [3:0]    w_lows;
  logic [2:0]    w_idx;
  logic          w_valid;
  logic          w_same;
  logic          r_valid;
  logic [2:0]    r_idx;
  logic [6:0]    r_seg;
  logic [CW-1:0] r_cnt;

  always_comb begin
    w_lows = '0;
    w_idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!i_an[i]) begin
        w_lows = w_lows + 4'd1;
        w_idx  = 3'(i);
      end
    end
  end

  assign w_valid   = (w_lows == 4'd1);
  assign o_illegal = (w_lows > 4'd1);
  assign w_same    = ({w_valid, w_idx, i_seg}
                   == {r_valid, r_idx, r_seg});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_seg   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_valid;
      r_idx   <= w_idx;
      r_seg   <= i_seg;
      if (!w_same)
        r_cnt <= CW'(1);
      else if (r_cnt != CMAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires on the edge where the count reaches the threshold,
  // so the commit lands together with the saturating step.
  assign o_commit  = w_valid && w_same
                  && (r_cnt == CMAX - CW'(1));
  assign o_idx     = w_idx;
  assign o_pattern = i_seg;

endmodule

// File: rtl/seg_scan_capture.sv
// Rebuilds the 8-digit frame from the scanned seven-segment bus.
// Ports: clk, reset (async high), bus (slave modport of the scan bus).
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic               clk,
  input logic               reset,
  seg_scan_capture_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [7:0]    w_an;
  logic          w_commit;
  logic [2:0]    w_idx;
  logic [6:0]    w_pattern;
  logic          w_illegal;
  logic          w_frame_ok;
  state_t        r_state;
  logic [2:0]    r_exp;
  logic [TW-1:0] r_tmo;
  logic          r_done;
  logic          r_err;
  logic          r_match;
  logic [6:0]    r_buf [8];

  assign w_an = {bus.an7, bus.an6, bus.an5, bus.an4,
                 bus.an3, bus.an2, bus.an1, bus.an0};

  seg_stable_detect #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_det (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_an     (w_an),
    .i_seg    (bus.seg_in),
    .o_commit (w_commit),
    .o_idx    (w_idx),
    .o_pattern(w_pattern),
    .o_illegal(w_illegal)
  );

  // Digit 7 is still in flight when match is decided, so it is
  // taken from the live pattern instead of the buffer.
  always_comb begin
    w_frame_ok = (w_pattern == GAME_OVER_MSG[7]);
    for (int i = 0; i < 7; i++)
      if (r_buf[i] != GAME_OVER_MSG[i])
        w_frame_ok = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SYNC;
      r_exp   <= '0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_match <= 1'b0;
      for (int i = 0; i < 8; i++)
        r_buf[i] <= BLANK;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_commit)
        r_tmo <= '0;
      else if (r_tmo != TMAX)
        r_tmo <= r_tmo + TW'(1);

      if (w_illegal) begin
        r_state <= ST_SYNC;
        r_exp   <= '0;
        r_err   <= 1'b1;
        r_match <= 1'b0;
      end else begin
        unique case (r_state)
          ST_SYNC: begin
            if (w_commit && w_idx == 3'd0) begin
              r_buf[0] <= w_pattern;
              r_exp    <= 3'd1;
              r_state  <= ST_COLLECT;
            end
          end
          ST_COLLECT, ST_DONE: begin
            if (w_commit && w_idx == r_exp) begin
              r_buf[w_idx] <= w_pattern;
              r_exp        <= r_exp + 3'd1;
              if (w_idx == 3'd7) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_match <= w_frame_ok;
              end else begin
                r_state <= ST_COLLECT;
              end
            end else if (w_commit) begin
              r_err   <= 1'b1;
              r_state <= ST_SYNC;
              r_exp   <= '0;
              r_match <= 1'b0;
            end else if (r_state == ST_COLLECT
                      && r_tmo == TMAX) begin
              r_state <= ST_SYNC;
              r_exp   <= '0;
              r_match <= 1'b0;
            end else begin
              r_state <= ST_COLLECT;
            end
          end
          default: r_state <= ST_SYNC;
        endcase
      end
    end
  end

  assign bus.rd_seg     = r_buf[bus.rd_idx];
  assign bus.frame_done = r_done;
  assign bus.frame_err  = r_err;
  assign bus.match      = r_match;
  assign bus.synced     = (r_state != ST_SYNC);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture.
// Frame/error events are queued at stimulus time, popped on pulses.
module tb_seg_scan_capture;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  typedef struct {
    bit is_err;
    bit match;
  } ev_t;

  ev_t sb_q[$];

  logic [6:0] msg [8] = '{
    7'b0001000, 7'b0000110, 7'b1000001, 7'b1000000,
    7'b0000110, 7'b1001000, 7'b0001000, 7'b0000010
  };

  seg_scan_capture_if bus ();

  seg_scan_capture #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (bus.frame_done || bus.frame_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexp_evt",
            {30'd0, bus.frame_done, bus.frame_err}, 0);
      end else begin
        e = sb_q.pop_front();
        chk("evt_err", 32'(bus.frame_err), 32'(e.is_err));
        chk("evt_done", 32'(bus.frame_done),
            32'(!e.is_err));
        if (!e.is_err)
          chk("frame_match", 32'(bus.match), 32'(e.match));
      end
    end
  end

  task automatic set_an(input logic [7:0] a);
    {bus.an7, bus.an6, bus.an5, bus.an4,
     bus.an3, bus.an2, bus.an1, bus.an0} = a;
  endtask

  task automatic dwell(input int idx,
                       input logic [6:0] pat,
                       input int n);
    logic [7:0] a;
    a = ~(8'b1 << idx);
    set_an(a);
    bus.seg_in = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_an(8'hFF);
    bus.seg_in = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag,
                      input logic [2:0] idx,
                      input logic [6:0] exp);
    bus.rd_idx = idx;
    #1;
    chk(tag, 32'(bus.rd_seg), 32'(exp));
  endtask

  task automatic frame(input logic [6:0] d3,
                       input bit exp_match);
    ev_t e;
    e.is_err = 1'b0;
    e.match  = exp_match;
    sb_q.push_back(e);
    for (int i = 0; i < 8; i++) begin
      dwell(i, (i == 3) ? d3 : msg[i], 8);
      if (i == 0)
        chk("synced_lock", 32'(bus.synced), 1);
    end
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.match  = 1'b0;
    sb_q.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    set_an(8'hFF);
    bus.seg_in = 7'h7F;
    bus.rd_idx = 3'd0;
    #3;
    chk("rst_synced", 32'(bus.synced), 0);
    chk("rst_match", 32'(bus.match), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_err", 32'(bus.frame_err), 0);
    peek("rst_buf0", 3'd0, 7'h7F);
    peek("rst_buf7", 3'd7, 7'h7F);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(3);

    frame(msg[3], 1'b1);
    frame(msg[3], 1'b1);
    chk("clean_match", 32'(bus.match), 1);
    peek("clean_buf7", 3'd7, 7'b0000010);

    frame(7'b1111001, 1'b0);
    chk("wrong_match", 32'(bus.match), 0);
    peek("wrong_buf3", 3'd3, 7'b1111001);

    reset = 1'b1;
    #1;
    reset = 1'b0;
    idle(2);
    dwell(0, msg[0], 8);
    dwell(1, msg[1], 8);
    push_err();
    dwell(3, msg[3], 8);
    chk("order_synced", 32'(bus.synced), 0);
    peek("order_buf3", 3'd3, 7'h7F);
    peek("order_buf1", 3'd1, msg[1]);
    idle(2);

    frame(msg[3], 1'b1);
    chk("pre_ill_match", 32'(bus.match), 1);
    dwell(0, msg[0], 8);
    dwell(1, msg[1], 8);
    push_err();
    set_an(8'b1101_1011);
    @(posedge clk);
    #1;
    idle(2);
    chk("ill_match", 32'(bus.match), 0);
    chk("ill_synced", 32'(bus.synced), 0);
    frame(msg[3], 1'b1);
    chk("relock_match", 32'(bus.match), 1);

    dwell(0, msg[0], 8);
    dwell(1, 7'b1111110, 2);
    idle(1);
    peek("short_buf1", 3'd1, msg[1]);
    chk("short_synced", 32'(bus.synced), 1);
    idle(70);
    chk("tmo_synced", 32'(bus.synced), 0);
    chk("tmo_match", 32'(bus.match), 0);

    frame(msg[3], 1'b1);
    for (int i = 0; i < 5; i++)
      dwell(i, msg[i], 8);
    chk("pre_rst_synced", 32'(bus.synced), 1);
    chk("pre_rst_match", 32'(bus.match), 1);
    reset = 1'b1;
    #1;
    chk("mrst_synced", 32'(bus.synced), 0);
    chk("mrst_match", 32'(bus.match), 0);
    chk("mrst_done", 32'(bus.frame_done), 0);
    chk("mrst_err", 32'(bus.frame_err), 0);
    for (int i = 0; i < 8; i++)
      peek("mrst_buf", 3'(i), 7'h7F);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
